// File: rtl/spectrum_peak_hold_if.sv
// Bin hand-over from the sdft read-out plus the resulting freq_bram write port.
interface spectrum_peak_hold_if #(
    parameter int unsigned bin_addr_w = 4,
    parameter int unsigned freq_w     = 9,
    parameter int unsigned out_w      = 9
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [bin_addr_w-1:0]    in_addr;
    logic signed [freq_w-1:0] in_real;
    logic signed [freq_w-1:0] in_imag;
    logic                     out_w_en;
    logic [bin_addr_w-1:0]    out_w_addr;
    logic [out_w-1:0]         out_data;

    modport master (
        output in_valid, in_addr, in_real, in_imag,
        input  in_ready, out_w_en, out_w_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_real, in_imag,
        output in_ready, out_w_en, out_w_addr, out_data
    );
endinterface

// File: rtl/spectrum_peak_hold.sv
// Per-bin power computation with peak-hold and periodic decay, feeding freq_bram.
module spectrum_peak_hold #(
    parameter int unsigned freq_bins    = 16,
    parameter int unsigned bin_addr_w   = 4,
    parameter int unsigned freq_w       = 9,
    parameter int unsigned out_w        = 9,
    parameter int unsigned power_shift  = 8,
    parameter int unsigned decay_frames = 4,
    parameter int unsigned decay_step   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold_en,
    input  logic                 clear,
    spectrum_peak_hold_if.slave  bus
);
    localparam int unsigned sq_w  = 2 * freq_w;
    localparam int unsigned sum_w = 2 * freq_w + 1;
    localparam int unsigned cnt_w = (decay_frames > 1) ? $clog2(decay_frames) : 1;
    localparam int unsigned idx_w = (freq_bins > 1) ? $clog2(freq_bins) : 1;
    localparam logic [sum_w-1:0] p_max = sum_w'(2 ** out_w - 1);

    typedef enum logic [1:0] {IDLE, SQ, CMP, WR} state_t;

    state_t                   state_q, state_d;
    logic [bin_addr_w-1:0]    addr_q, addr_d;
    logic signed [freq_w-1:0] re_q, re_d, im_q, im_d;
    logic [sq_w-1:0]          re_sq_q, re_sq_d, im_sq_q, im_sq_d;
    logic [out_w-1:0]         p_q, p_d, n_q, n_d;
    logic [cnt_w-1:0]         frame_cnt_q, frame_cnt_d;
    logic [out_w-1:0]         hold_q [freq_bins];
    logic [out_w-1:0]         hold_d [freq_bins];
    logic                     in_ready_q, in_ready_d;
    logic                     out_w_en_q, out_w_en_d;
    logic [bin_addr_w-1:0]    out_w_addr_q, out_w_addr_d;
    logic [out_w-1:0]         out_data_q, out_data_d;

    logic signed [sq_w-1:0]   re_sq_s_c, im_sq_s_c;
    logic [sum_w-1:0]         sum_c, pw_c;
    logic [out_w-1:0]         p_c, h_c, h_dec_c, step_c, wr_val_c;
    logic [idx_w-1:0]         idx_c;
    logic                     in_range_c, decay_frame_c;

    // Datapath helpers: squares (signed, so -2**(freq_w-1) squares without overflow), power, decayed hold
    always_comb begin
        re_sq_s_c     = sq_w'(re_q) * sq_w'(re_q);
        im_sq_s_c     = sq_w'(im_q) * sq_w'(im_q);
        sum_c         = sum_w'(re_sq_q) + sum_w'(im_sq_q);
        pw_c          = sum_c >> power_shift;
        p_c           = (pw_c > p_max) ? out_w'(p_max) : out_w'(pw_c);
        in_range_c    = (32'(addr_q) < freq_bins);
        idx_c         = idx_w'(addr_q);
        h_c           = in_range_c ? hold_q[idx_c] : '0;
        step_c        = out_w'(decay_step);
        decay_frame_c = (32'(frame_cnt_q) == decay_frames - 1);
        h_dec_c       = h_c;
        if (decay_frame_c) begin
            h_dec_c = (h_c > step_c) ? (h_c - step_c) : '0;
        end
    end

    // Next-state and registered-output logic for the IDLE -> SQ -> CMP -> WR pipeline
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        re_d         = re_q;
        im_d         = im_q;
        re_sq_d      = re_sq_q;
        im_sq_d      = im_sq_q;
        p_d          = p_q;
        n_d          = n_q;
        frame_cnt_d  = frame_cnt_q;
        hold_d       = hold_q;
        out_w_en_d   = 1'b0;
        out_w_addr_d = out_w_addr_q;
        out_data_d   = out_data_q;
        wr_val_c     = n_q;

        if (clear) begin
            for (int i = 0; i < int'(freq_bins); i++) begin
                hold_d[i] = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    addr_d  = bus.in_addr;
                    re_d    = bus.in_real;
                    im_d    = bus.in_imag;
                    state_d = SQ;
                end
            end
            SQ: begin
                re_sq_d = $unsigned(re_sq_s_c);
                im_sq_d = $unsigned(im_sq_s_c);
                state_d = CMP;
            end
            CMP: begin
                p_d = p_c;
                n_d = p_c;
                // A clear in this cycle means the held value is treated as zero
                if (hold_en && !clear && (h_dec_c > p_c)) begin
                    n_d = h_dec_c;
                end
                state_d = WR;
            end
            WR: begin
                wr_val_c = clear ? p_q : n_q;
                if (in_range_c) begin
                    hold_d[idx_c] = wr_val_c;
                    out_w_en_d    = 1'b1;
                    out_w_addr_d  = addr_q;
                    out_data_d    = wr_val_c;
                    if (32'(addr_q) == freq_bins - 1) begin
                        frame_cnt_d = decay_frame_c ? '0 : frame_cnt_q + cnt_w'(1);
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            re_q         <= '0;
            im_q         <= '0;
            re_sq_q      <= '0;
            im_sq_q      <= '0;
            p_q          <= '0;
            n_q          <= '0;
            frame_cnt_q  <= '0;
            in_ready_q   <= 1'b1;
            out_w_en_q   <= 1'b0;
            out_w_addr_q <= '0;
            out_data_q   <= '0;
            for (int i = 0; i < int'(freq_bins); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            re_q         <= re_d;
            im_q         <= im_d;
            re_sq_q      <= re_sq_d;
            im_sq_q      <= im_sq_d;
            p_q          <= p_d;
            n_q          <= n_d;
            frame_cnt_q  <= frame_cnt_d;
            in_ready_q   <= in_ready_d;
            out_w_en_q   <= out_w_en_d;
            out_w_addr_q <= out_w_addr_d;
            out_data_q   <= out_data_d;
            hold_q       <= hold_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_w_en   = out_w_en_q;
    assign bus.out_w_addr = out_w_addr_q;
    assign bus.out_data   = out_data_q;

endmodule
